// File: rtl/audio_stream_pkg.sv
// Shared register map, bit positions and sizing helpers for the buffered PDM audio peripheral.
package audio_stream_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_DIV    = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h08;
    localparam logic [7:0] REG_DATA   = 8'h0C;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FLUSH  = 2;

    localparam int unsigned LEVEL_W        = 9;
    localparam int unsigned STAT_FULL      = 9;
    localparam int unsigned STAT_EMPTY     = 10;
    localparam int unsigned STAT_UNDERFLOW = 11;
    localparam int unsigned STAT_OVERFLOW  = 12;

    function automatic int unsigned frame_width(input int unsigned channels,
                                                input int unsigned sample_width);
        return channels * sample_width;
    endfunction

endpackage

// File: rtl/pdm_dac_n.sv
// First-order sigma-delta modulator for one channel; the carry out of the accumulator is the bit.
module pdm_dac_n #(
    parameter int unsigned SAMPLE_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    pdm_out
);

    logic [SAMPLE_WIDTH:0] acc_q, acc_d;

    // Disabled channels sit at zero so the pin stays quiet until playback starts.
    always_comb begin
        acc_d = '0;
        if (en) begin
            acc_d = {1'b0, acc_q[SAMPLE_WIDTH-1:0]} + {1'b0, sample};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign pdm_out = acc_q[SAMPLE_WIDTH];

endmodule

// File: rtl/audio_stream.sv
// Buffered multi-channel PDM audio peripheral on the iomem bus: frame FIFO, sample timer, flags.
module audio_stream
    import audio_stream_pkg::*;
#(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned SAMPLE_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned DIV_WIDTH    = 16,
    parameter logic [7:0]  BASE_HI      = 8'h04
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    output logic                irq,
    output logic [CHANNELS-1:0] pdm_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned FW = frame_width(CHANNELS, SAMPLE_WIDTH);
    localparam logic [PW-1:0] FULL_LVL = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] HALF_LVL = PW'(FIFO_DEPTH / 2);
    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    logic                    ready_q;
    logic [31:0]             rdata_q, rdata_d;
    logic                    en_q, irq_en_q;
    logic [DIV_WIDTH-1:0]    div_q, cnt_q, cnt_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           lvl_q, lvl_d;
    logic                    udf_q, udf_d, ovf_q, ovf_d;
    logic [SAMPLE_WIDTH-1:0] hold_q [CHANNELS];
    logic [FW-1:0]           mem [FIFO_DEPTH];
    logic [FW-1:0]           frame;

    logic       sel, wr, rd, wr_ctrl, wr_div, wr_status, wr_data, flush;
    logic       full, empty, tick, push, pop;
    logic [7:0] off;
    logic       unused_bits;

    assign off       = iomem_addr[7:0];
    assign sel       = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_HI);
    assign wr        = sel && (|iomem_wstrb);
    assign rd        = sel && !(|iomem_wstrb);
    assign wr_ctrl   = wr && (off == REG_CTRL);
    assign wr_div    = wr && (off == REG_DIV);
    assign wr_status = wr && (off == REG_STATUS);
    assign wr_data   = wr && (off == REG_DATA);
    assign flush     = wr_ctrl && iomem_wdata[CTRL_FLUSH];
    assign unused_bits = ^{iomem_addr[23:8], iomem_wdata};

    assign lvl_q = wr_ptr_q - rd_ptr_q;
    assign full  = (lvl_q == FULL_LVL);
    assign empty = (lvl_q == '0);
    assign tick  = en_q && (cnt_q == '0);
    // Fullness is judged before any pop on the same edge, so a full FIFO drops the frame.
    assign push  = wr_data && !full;
    assign pop   = tick && !empty && !flush;

    always_comb begin
        frame = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            frame[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = iomem_wdata[16*c +: SAMPLE_WIDTH];
        end
    end

    always_comb begin
        cnt_d = cnt_q - DIV_WIDTH'(1);
        if (!en_q || cnt_q == '0) begin
            cnt_d = div_q;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
        lvl_d = wr_ptr_d - rd_ptr_d;

        // Clear-on-write first, so an event on the same edge still leaves the flag set.
        udf_d = udf_q;
        ovf_d = ovf_q;
        if (wr_status && iomem_wdata[STAT_UNDERFLOW]) udf_d = 1'b0;
        if (wr_status && iomem_wdata[STAT_OVERFLOW])  ovf_d = 1'b0;
        if (tick && empty)   udf_d = 1'b1;
        if (wr_data && full) ovf_d = 1'b1;

        rdata_d = '0;
        if (rd) begin
            case (off)
                REG_CTRL: begin
                    rdata_d[CTRL_EN]     = en_q;
                    rdata_d[CTRL_IRQ_EN] = irq_en_q;
                end
                REG_DIV:  rdata_d[DIV_WIDTH-1:0] = div_q;
                REG_STATUS: begin
                    rdata_d[LEVEL_W-1:0]    = LEVEL_W'(lvl_d);
                    rdata_d[STAT_FULL]      = (lvl_d == FULL_LVL);
                    rdata_d[STAT_EMPTY]     = (lvl_d == '0);
                    rdata_d[STAT_UNDERFLOW] = udf_d;
                    rdata_d[STAT_OVERFLOW]  = ovf_d;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            udf_q    <= 1'b0;
            ovf_q    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) hold_q[c] <= MIDSCALE;
        end else begin
            ready_q  <= sel;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            udf_q    <= udf_d;
            ovf_q    <= ovf_d;
            if (wr_ctrl) begin
                en_q     <= iomem_wdata[CTRL_EN];
                irq_en_q <= iomem_wdata[CTRL_IRQ_EN];
            end
            if (wr_div) div_q <= iomem_wdata[DIV_WIDTH-1:0];
            if (pop) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    hold_q[c] <= mem[rd_ptr_q[AW-1:0]][c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= frame;
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq = irq_en_q & en_q & ((lvl_q < HALF_LVL) | udf_q);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_dac
        pdm_dac_n #(
            .SAMPLE_WIDTH(SAMPLE_WIDTH)
        ) u_dac (
            .clk    (clk),
            .resetn (resetn),
            .en     (en_q),
            .sample (hold_q[c]),
            .pdm_out(pdm_out[c])
        );
    end

endmodule

// File: tb/tb_audio_stream.sv
// Bench for audio_stream: queue-based behavioural model checked every cycle, plus pinned literals.
module tb_audio_stream;

    localparam int         CH    = 2;
    localparam int         SW    = 12;
    localparam int         DEPTH = 16;
    localparam logic [7:0] BASE  = 8'h04;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        irq;
    logic [CH-1:0] pdm_out;

    audio_stream #(
        .CHANNELS    (CH),
        .SAMPLE_WIDTH(SW),
        .FIFO_DEPTH  (DEPTH),
        .DIV_WIDTH   (16),
        .BASE_HI     (BASE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .irq        (irq),
        .pdm_out    (pdm_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // Model state: what the peripheral holds after the most recent rising edge.
    bit          m_ready = 0;
    logic [31:0] m_rdata = 0;
    bit          m_en = 0, m_irq_en = 0, m_udf = 0, m_ovf = 0;
    int          m_div = 0, m_wait = 0;
    logic [31:0] m_q[$];
    int          m_hold[CH] = '{2048, 2048};
    int          m_acc[CH] = '{0, 0};

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] status_word();
        int lvl = m_q.size();
        return 32'(lvl) | (32'(lvl == DEPTH) << 9) | (32'(lvl == 0) << 10)
             | (32'(m_udf) << 11) | (32'(m_ovf) << 12);
    endfunction

    always @(posedge clk) begin : model
        bit sel, wr, rd, flush, tick;
        logic [7:0] off;
        logic [31:0] f;
        int size;
        if (!resetn) begin
            m_ready = 0; m_rdata = 0; m_en = 0; m_irq_en = 0; m_udf = 0; m_ovf = 0;
            m_div = 0; m_wait = 0; m_q.delete();
            for (int c = 0; c < CH; c++) begin m_hold[c] = 2048; m_acc[c] = 0; end
        end else begin
            sel   = iomem_valid && !m_ready && (iomem_addr[31:24] == BASE);
            wr    = sel && (iomem_wstrb != 0);
            rd    = sel && (iomem_wstrb == 0);
            off   = iomem_addr[7:0];
            flush = wr && off == 8'h00 && iomem_wdata[2];
            size  = m_q.size();
            // A sample is due when the enabled timer has waited out its period.
            tick  = m_en && m_wait == 0;
            for (int c = 0; c < CH; c++)
                m_acc[c] = m_en ? (m_acc[c] % (1 << SW)) + m_hold[c] : 0;
            m_wait = (m_en && m_wait != 0) ? m_wait - 1 : m_div;
            if (wr && off == 8'h08) begin
                if (iomem_wdata[11]) m_udf = 0;
                if (iomem_wdata[12]) m_ovf = 0;
            end
            if (tick) begin
                if (size == 0) m_udf = 1;
                else if (!flush) begin
                    f = m_q.pop_front();
                    for (int c = 0; c < CH; c++) m_hold[c] = int'((f >> (16 * c)) & 32'hFFF);
                end
            end
            if (wr && off == 8'h0C) begin
                if (size == DEPTH) m_ovf = 1;
                else m_q.push_back(iomem_wdata);
            end
            if (flush) m_q.delete();
            if (wr && off == 8'h00) begin m_en = iomem_wdata[0]; m_irq_en = iomem_wdata[1]; end
            if (wr && off == 8'h04) m_div = int'(iomem_wdata & 32'hFFFF);
            m_rdata = 0;
            if (rd) begin
                case (off)
                    8'h00: m_rdata = {30'h0, m_irq_en, m_en};
                    8'h04: m_rdata = 32'(m_div);
                    8'h08: m_rdata = status_word();
                    default: m_rdata = 0;
                endcase
            end
            m_ready = sel;
        end
    end

    always @(negedge clk) begin : compare
        logic [CH-1:0] exp_pdm;
        bit exp_irq;
        if (checking) begin
            for (int c = 0; c < CH; c++) exp_pdm[c] = ((m_acc[c] >> SW) & 1) != 0;
            exp_irq = m_irq_en && m_en && ((m_q.size() < DEPTH / 2) || m_udf);
            check("ready", 32'(iomem_ready), 32'(m_ready));
            if (m_ready) check("rdata", iomem_rdata, m_rdata);
            check("irq", 32'(irq), 32'(exp_irq));
            check("pdm_out", 32'(pdm_out), 32'(exp_pdm));
        end
    end

    function automatic logic [31:0] adr(input logic [7:0] off);
        return {BASE, 16'h0000, off};
    endfunction

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data, output logic [31:0] rdat);
        int n = 0;
        iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = data;
        @(negedge clk);
        while (!iomem_ready && n < 8) begin @(negedge clk); n++; end
        check("bus_ack", 32'(iomem_ready), 32'h1);
        rdat = iomem_rdata;
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        logic [31:0] d;
        bus(adr(off), 4'hF, data, d);
    endtask

    task automatic rd_expect(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus(adr(off), 4'h0, 32'h0, d);
        check(name, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        idle(3);
        checking = 1'b1;
        resetn = 1'b1;

        rd_expect("reset_status", 8'h08, 32'h0000_0400);
        rd_expect("reset_ctrl", 8'h00, 32'h0);
        rd_expect("reset_div", 8'h04, 32'h0);

        // Full-scale then midscale playback with a 4-cycle sample period.
        wr(8'h04, 32'd3);
        wr(8'h0C, 32'h0000_0FFF);
        wr(8'h0C, 32'h0800_0800);
        wr(8'h00, 32'h1);
        idle(40);

        // Reset while playing, then overfill with playback disabled.
        do_reset();
        for (int i = 0; i < 17; i++) wr(8'h0C, 32'(i * 32'h0001_0011));
        rd_expect("ovf_status", 8'h08, 32'h0000_1210);
        wr(8'h08, 32'h0000_1000);
        rd_expect("ovf_cleared", 8'h08, 32'h0000_0210);

        // Underflow on an empty FIFO and the resulting interrupt.
        do_reset();
        wr(8'h04, 32'd20);
        wr(8'h00, 32'h3);
        idle(30);
        rd_expect("udf_status", 8'h08, 32'h0000_0C00);
        check("udf_irq", 32'(irq), 32'h1);
        wr(8'h08, 32'h0000_0800);
        for (int i = 0; i < 10; i++) wr(8'h0C, $urandom);
        idle(5);

        // Tick every cycle with back-to-back pushes.
        wr(8'h04, 32'd0);
        for (int i = 0; i < 12; i++) wr(8'h0C, $urandom);

        // Flush with frames queued.
        do_reset();
        for (int i = 0; i < 5; i++) wr(8'h0C, $urandom);
        wr(8'h00, 32'h4);
        rd_expect("flush_status", 8'h08, 32'h0000_0400);
        rd_expect("flush_ctrl", 8'h00, 32'h0);

        for (int i = 0; i < 500; i++) begin
            int op = $urandom_range(0, 99);
            if (op < 30) wr(8'h0C, $urandom);
            else if (op < 40)
                wr(8'h00, ((($urandom_range(0, 9) == 0) ? 32'h4 : 32'h0)) | $urandom_range(0, 3));
            else if (op < 48) wr(8'h04, $urandom_range(0, 6));
            else if (op < 58) wr(8'h08, $urandom & 32'h0000_1800);
            else if (op < 78) begin
                logic [7:0] offs[6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20};
                bus(adr(offs[$urandom_range(0, 5)]), 4'h0, 32'h0, d);
            end
            else if (op < 84) wr(8'h14, $urandom);
            else if (op < 91) begin
                logic [7:0] hi = BASE ^ 8'($urandom_range(1, 255));
                iomem_valid = 1'b1; iomem_wstrb = 4'($urandom); iomem_wdata = $urandom;
                iomem_addr = {hi, 16'h0, 8'h0C};
                idle(3);
                iomem_valid = 1'b0; iomem_wstrb = 4'h0;
            end
            else if (op < 98) idle($urandom_range(1, 15));
            else do_reset();
        end

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_stream.md
# audio_stream

Buffered, parametrised multi-channel PDM audio peripheral on the PicoSoC iomem bus. It replaces the single unbuffered 12-bit audio register with per-frame sample FIFOs and a programmable sample-rate timer. It also adds underflow and overflow flags and a FIFO-level interrupt. It sits in the SoC top, decodes its own iomem address window, and drives one PDM output pin per channel.

## Interface
Parameters:
- CHANNELS, 2: audio channels, legal values 1..2.
- SAMPLE_WIDTH, 12: bits per sample, legal values 8..16, unsigned.
- FIFO_DEPTH, 16: frames buffered, power of two, 4..256.
- DIV_WIDTH, 16: width of the sample-period divider.
- BASE_HI, 8'h04: iomem_addr[31:24] value that selects this block.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- iomem_valid  in  1  bus request.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_wstrb  in  4  byte write strobes; 0 means read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data, valid while iomem_ready=1.
- irq  out  1  level interrupt.
- pdm_out  out  CHANNELS  PDM bitstream per channel.

## Operation
- Select condition: iomem_valid && !iomem_ready && addr[31:24]==BASE_HI. On select, ready=1 for exactly one cycle. Unselected cycles keep ready=0.
- Register map, addr[7:0]; unmapped offsets read 0 and ignore writes:
  - 0x00 CTRL (rw): bit0 EN, bit1 IRQ_EN, bit2 FLUSH (self-clearing, reads 0).
  - 0x04 DIV (rw): sample period − 1, in clk cycles, DIV_WIDTH bits.
  - 0x08 STATUS: [8:0] level, bit9 FULL, bit10 EMPTY, bit11 UNDERFLOW, bit12 OVERFLOW. Flags are sticky; writing 1 to bit11 or bit12 clears that flag.
  - 0x0C DATA (wo): push one frame. Channel c takes wdata[16c+SAMPLE_WIDTH-1:16c]. A push occurs when any wstrb bit is set.
- Push when FULL: frame dropped, OVERFLOW set. Fullness is evaluated before any same-cycle pop.
- Divider: down-counter reloads with DIV when it reaches 0. The cycle at 0 is a tick. While EN=0 the counter is held at DIV.
- Tick with EN=1:
  - FIFO non-empty: pop one frame into the per-channel hold registers.
  - FIFO empty: hold registers unchanged, UNDERFLOW set.
- Simultaneous push and pop (not full): both happen; level unchanged.
- FLUSH: level forced to 0 and pointers reset on the write cycle. A pop in that cycle is suppressed. A DATA write cannot coincide, since it is a different address.
- irq = IRQ_EN & EN & ((level < FIFO_DEPTH/2) | UNDERFLOW).
- PDM per channel is first-order sigma-delta:
  - acc[SAMPLE_WIDTH:0] <= acc[SAMPLE_WIDTH-1:0] + hold.
  - pdm_out = acc[SAMPLE_WIDTH], registered.

## Timing
- Reset values:
  - ready=0, rdata=0, irq=0, pdm_out=0.
  - CTRL=0, DIV=0, level=0, all flags 0.
  - Hold registers = midscale 1<<(SAMPLE_WIDTH-1); accumulators = 0.
- Bus latency: ready is asserted on the cycle after valid rises. rdata is registered and presented with ready. Register writes take effect on the same clock edge that raises ready.
- STATUS read reflects state at the edge that raises ready, including a push or pop on that edge.
- Tick to pop: the hold register updates on the tick edge. The PDM accumulator uses the new value from the following cycle.
- DIV=0: tick every cycle. DIV=N: tick every N+1 cycles.
- DIV written while EN=1: new value is used at the next reload; the current count is not disturbed.
- Reset asserted mid-operation: all state returns to reset values on the next edge; the FIFO contents are discarded and the level reads 0.

## Structure
- Package audio_stream_pkg holds:
  - Register offsets: REG_CTRL, REG_DIV, REG_STATUS, REG_DATA.
  - CTRL and STATUS bit-index constants.
  - Frame width function CHANNELS*SAMPLE_WIDTH.
- One sub-module, pdm_dac_n: parametrised by SAMPLE_WIDTH, instantiated CHANNELS times.
- FIFO is inline: a single frame-wide RAM array with pointers one bit wider than log2(FIFO_DEPTH).

## Test plan
- Reset, then read 0x08 -> 0x00000400 (EMPTY only). pdm_out stays 0 until EN. irq=0.
- DIV=3, EN=1, push frames 0x0FFF/0x0000, then 0x0800/0x0800 -> hold values change every 4 cycles. Ch0 PDM density ≈ 4095/4096 during frame 1, then 50%. Ch1 density is 0 during frame 1.
- Push 17 frames into a depth-16 FIFO with EN=0 -> STATUS level=16, FULL=1, OVERFLOW=1. Write 1 to bit12 -> OVERFLOW clears; FULL stays 1.
- EN=1 with FIFO empty -> UNDERFLOW=1 on the first tick and hold stays at midscale 0x800. IRQ_EN=1 -> irq=1. Write 1 to bit11 with frames pushed -> irq drops once level ≥ 8.
- DIV=0 with a push arriving on every tick -> level stays constant (simultaneous push/pop) and no flags are set.
- 5 frames queued, write CTRL FLUSH -> next STATUS read shows level 0, EMPTY=1. The hold register keeps its last value.
